hero_attack_ctl: RTL and testbench

Generates the sword/attack hitbox for both heroes and feeds the enemy control units through `hero_attack_x_pos`, `hero_attack_y_pos` and `attack_direction`. A synchronised button press starts a timed ACTIVE window, followed by a COOLDOWN. During ACTIVE the hitbox is placed next to each hero according to the facing latched at the trigger. Outside ACTIVE the hitbox is parked off-screen, so enemies cannot register a hit.

---
 rtl/binary_land_pkg.sv | 57 +++++
 rtl/btn_edge_sync.sv | 37 +++
 rtl/hero_attack_ctl.sv | 171 +++++++++++++++++
 tb/tb_hero_attack_ctl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/binary_land_pkg.sv
`default_nettype none
// ============================================================================
// Module      : binary_land_pkg
// Description : Shared constants for the hero attack logic. Covers facing
//               codes, attack state encoding, sprite/hitbox geometry, the
//               parked hitbox position and hitbox placement helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package binary_land_pkg;

  // Hero facing codes, as driven on hero_facing
  localparam logic [1:0] FACE_UP    = 2'd0;
  localparam logic [1:0] FACE_LEFT  = 2'd1;
  localparam logic [1:0] FACE_RIGHT = 2'd2;
  localparam logic [1:0] FACE_DOWN  = 2'd3;

  // Attack state encoding
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ACTIVE   = 2'd1;
  localparam logic [1:0] COOLDOWN = 2'd2;

  // Geometry, in 12-bit screen coordinates
  localparam logic [11:0] SQUARE_SIDE   = 12'd60;
  localparam logic [11:0] ATTACK_WIDTH  = 12'd40;
  localparam logic [11:0] ATTACK_HEIGHT = 12'd20;
  localparam logic [11:0] ATTACK_OFFSET = (SQUARE_SIDE - ATTACK_HEIGHT) / 12'd2;
  localparam logic [11:0] PARK_X        = 12'd1025;
  localparam logic [11:0] PARK_Y        = 12'd0;

  // Subtraction that clamps at the screen edge instead of wrapping
  function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
    return (a > b) ? (a - b) : 12'd0;
  endfunction

  // Hero 2 faces the opposite horizontal direction from hero 1
  function automatic logic [1:0] mirror_facing(input logic [1:0] f);
    case (f)
      FACE_LEFT:  return FACE_RIGHT;
      FACE_RIGHT: return FACE_LEFT;
      default:    return f;
    endcase
  endfunction

  // Hitbox top-left corner for one hero, returned as {x, y}
  function automatic logic [23:0] hitbox_pos(input logic [1:0]  f,
                                             input logic [11:0] hx,
                                             input logic [11:0] hy);
    case (f)
      FACE_RIGHT: return {hx + SQUARE_SIDE, hy + ATTACK_OFFSET};
      FACE_LEFT:  return {sat_sub(hx, ATTACK_WIDTH), hy + ATTACK_OFFSET};
      FACE_UP:    return {hx + ATTACK_OFFSET, sat_sub(hy, ATTACK_WIDTH)};
      default:    return {hx + ATTACK_OFFSET, hy + SQUARE_SIDE};
    endcase
  endfunction

endpackage : binary_land_pkg
`default_nettype wire

// File: rtl/btn_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : btn_edge_sync
// Description : Two-flop synchroniser for an asynchronous button followed by
//               a rising-edge detector producing a one-clock pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule : btn_edge_sync
`default_nettype wire

// File: rtl/hero_attack_ctl.sv
`default_nettype none
// ============================================================================
// Module      : hero_attack_ctl
// Description : Attack hitbox generator for both heroes. A button press opens
//               a timed ACTIVE window followed by a COOLDOWN; while ACTIVE
//               the hitbox sits beside each hero, otherwise it is parked
//               off-screen. Optional macro ATTACK_AUTOREPEAT_EN re-arms the
//               attack directly from COOLDOWN while the button is held.
// Revision    : 1.0 - initial release
// ============================================================================
module hero_attack_ctl
  import binary_land_pkg::*;
#(
  parameter int TICK_DIV       = 666_667,
  parameter int ACTIVE_TICKS   = 15,
  parameter int COOLDOWN_TICKS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        level_rst,
  input  logic        btn_attack,
  input  logic [1:0]  hero_facing,
  input  logic [23:0] hero_x_pos,
  input  logic [23:0] hero_y_pos,
  output logic [23:0] hero_attack_x_pos,
  output logic [23:0] hero_attack_y_pos,
  output logic        attack_direction,
  output logic        attack_active
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT = (ACTIVE_TICKS > COOLDOWN_TICKS) ? ACTIVE_TICKS : COOLDOWN_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ACT_LAST   = CW'(ACTIVE_TICKS - 1);
  localparam logic [CW-1:0] CD_LAST    = CW'(COOLDOWN_TICKS - 1);

`ifdef ATTACK_AUTOREPEAT_EN
  localparam bit REPEAT_EN = 1'b1;
`else
  localparam bit REPEAT_EN = 1'b0;
`endif

  logic          rst_any_w;
  logic          btn_level_w;
  logic          trig_w;
  logic          tick_w;

  logic [1:0]    state_q,  state_d;
  logic [1:0]    facing_q, facing_d;
  logic [CW-1:0] cnt_q,    cnt_d;
  logic [PW-1:0] presc_q,  presc_d;

  logic [23:0]   place_x_w, place_y_w;
  logic [23:0]   x_q, x_d;
  logic [23:0]   y_q, y_d;
  logic          dir_q, dir_d;
  logic          active_q, active_d;

  assign rst_any_w = rst | level_rst;
  assign tick_w    = (presc_q == PRESC_LAST);

  btn_edge_sync u_btn_edge_sync (
    .clk     (clk),
    .rst     (rst_any_w),
    .btn_i   (btn_attack),
    .level_o (btn_level_w),
    .rise_o  (trig_w)
  );

  // Placement is computed from the facing that will be in force after this edge
  for (genvar h = 0; h < 2; h++) begin : g_hero
    logic [1:0] face_w;
    assign face_w = (h == 0) ? facing_d : mirror_facing(facing_d);
    assign {place_x_w[h*12 +: 12], place_y_w[h*12 +: 12]} =
      hitbox_pos(face_w, hero_x_pos[h*12 +: 12], hero_y_pos[h*12 +: 12]);
  end

  // State, timers, latched facing and registered outputs
  always_ff @(posedge clk) begin
    if (rst_any_w) begin
      state_q  <= IDLE;
      facing_q <= FACE_RIGHT;
      cnt_q    <= '0;
      presc_q  <= '0;
      x_q      <= {PARK_X, PARK_X};
      y_q      <= {PARK_Y, PARK_Y};
      dir_q    <= 1'b1;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      facing_q <= facing_d;
      cnt_q    <= cnt_d;
      presc_q  <= presc_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dir_q    <= dir_d;
      active_q <= active_d;
    end
  end

  // Next state: prescaler free-runs and restarts on entry to a timed state
  always_comb begin
    state_d  = state_q;
    facing_d = facing_q;
    cnt_d    = cnt_q;
    presc_d  = tick_w ? '0 : presc_q + 1'b1;
    case (state_q)
      IDLE: begin
        if (trig_w) begin
          state_d  = ACTIVE;
          facing_d = hero_facing;
          cnt_d    = '0;
          presc_d  = '0;
        end
      end
      ACTIVE: begin
        if (tick_w) begin
          if (cnt_q == ACT_LAST) begin
            state_d = COOLDOWN;
            cnt_d   = '0;
            presc_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      COOLDOWN: begin
        if (tick_w) begin
          if (cnt_q == CD_LAST) begin
            cnt_d   = '0;
            presc_d = '0;
            if (REPEAT_EN && btn_level_w) begin
              state_d  = ACTIVE;
              facing_d = hero_facing;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next values: place beside the heroes while ACTIVE, park otherwise
  always_comb begin
    active_d = (state_d == ACTIVE);
    x_d      = {PARK_X, PARK_X};
    y_d      = {PARK_Y, PARK_Y};
    dir_d    = dir_q;
    if (active_d) begin
      x_d   = place_x_w;
      y_d   = place_y_w;
      dir_d = (facing_d == FACE_LEFT) || (facing_d == FACE_RIGHT);
    end
  end

  assign hero_attack_x_pos = x_q;
  assign hero_attack_y_pos = y_q;
  assign attack_direction  = dir_q;
  assign attack_active     = active_q;

endmodule : hero_attack_ctl
`default_nettype wire

// File: tb/tb_hero_attack_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hero_attack_ctl
// Description : Self-checking bench for hero_attack_ctl. Directed scenarios
//               plus randomized stimulus, compared every clock against a
//               behavioural model that counts clocks left in each phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hero_attack_ctl;

  localparam int TD       = 4;
  localparam int AT       = 3;
  localparam int CT       = 2;
  localparam int ACT_CLKS = AT * TD;
  localparam int CD_CLKS  = CT * TD;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        level_rst = 1'b0;
  logic        btn_attack = 1'b0;
  logic [1:0]  hero_facing = 2'd2;
  logic [23:0] hero_x_pos = '0;
  logic [23:0] hero_y_pos = '0;
  logic [23:0] hero_attack_x_pos;
  logic [23:0] hero_attack_y_pos;
  logic        attack_direction;
  logic        attack_active;

  always #5 clk = ~clk;

  hero_attack_ctl #(
    .TICK_DIV       (TD),
    .ACTIVE_TICKS   (AT),
    .COOLDOWN_TICKS (CT)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .level_rst         (level_rst),
    .btn_attack        (btn_attack),
    .hero_facing       (hero_facing),
    .hero_x_pos        (hero_x_pos),
    .hero_y_pos        (hero_y_pos),
    .hero_attack_x_pos (hero_attack_x_pos),
    .hero_attack_y_pos (hero_attack_y_pos),
    .attack_direction  (attack_direction),
    .attack_active     (attack_active)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 active, 2 cooldown; m_left = clocks remaining in phase
  int       m_mode  = 0;
  int       m_left  = 0;
  int       m_face  = 2;
  bit [2:0] m_hist  = '0;   // button samples from 1, 2, 3 edges ago
  int       m_starts = 0;
  int       ex_x[2];
  int       ex_y[2];
  bit       ex_dir  = 1'b1;
  bit       ex_act  = 1'b0;

  function automatic void place(input int face, input int hx, input int hy,
                                output int ox, output int oy);
    case (face)
      0:       begin ox = hx + 20;                    oy = (hy > 40) ? hy - 40 : 0; end
      1:       begin ox = (hx > 40) ? hx - 40 : 0;    oy = hy + 20;                 end
      2:       begin ox = hx + 60;                    oy = hy + 20;                 end
      default: begin ox = hx + 20;                    oy = hy + 60;                 end
    endcase
  endfunction

  task automatic model_edge();
    bit trig;
    bit lvl;
    int f;
    if (rst || level_rst) begin
      m_mode = 0;
      m_hist = '0;
      m_face = 2;
      ex_dir = 1'b1;
    end else begin
      trig   = m_hist[1] && !m_hist[2];
      lvl    = m_hist[1];
      m_hist = {m_hist[1:0], btn_attack};
      if (m_mode == 0) begin
        if (trig) begin
          m_mode = 1; m_left = ACT_CLKS; m_face = int'(hero_facing); m_starts++;
        end
      end else if (m_mode == 1) begin
        m_left--;
        if (m_left == 0) begin m_mode = 2; m_left = CD_CLKS; end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_mode = 0;
`ifdef ATTACK_AUTOREPEAT_EN
          if (lvl) begin
            m_mode = 1; m_left = ACT_CLKS; m_face = int'(hero_facing); m_starts++;
          end
`endif
        end
      end
    end
    ex_act = (m_mode == 1);
    for (int h = 0; h < 2; h++) begin
      if (ex_act) begin
        f = m_face;
        if (h == 1 && f == 1) f = 2;
        else if (h == 1 && f == 2) f = 1;
        place(f, int'(hero_x_pos[h*12 +: 12]), int'(hero_y_pos[h*12 +: 12]), ex_x[h], ex_y[h]);
      end else begin
        ex_x[h] = 1025;
        ex_y[h] = 0;
      end
    end
    if (ex_act) ex_dir = (m_face == 1 || m_face == 2);
  endtask

  // One clock: drive on the falling edge, model at the rising edge, check 1 ns later
  task automatic step(input bit b, input bit r, input bit lr, input logic [1:0] f);
    @(negedge clk);
    btn_attack  = b;
    rst         = r;
    level_rst   = lr;
    hero_facing = f;
    @(posedge clk);
    model_edge();
    #1;
    check_val("active", 32'(attack_active), 32'(ex_act));
    check_val("dir",    32'(attack_direction), 32'(ex_dir));
    check_val("x_hero1", 32'(hero_attack_x_pos[11:0]),  32'(ex_x[0]));
    check_val("x_hero2", 32'(hero_attack_x_pos[23:12]), 32'(ex_x[1]));
    check_val("y_hero1", 32'(hero_attack_y_pos[11:0]),  32'(ex_y[0]));
    check_val("y_hero2", 32'(hero_attack_y_pos[23:12]), 32'(ex_y[1]));
  endtask

  task automatic set_heroes(input int x1, input int y1, input int x2, input int y2);
    hero_x_pos = {12'(x2), 12'(x1)};
    hero_y_pos = {12'(y2), 12'(y1)};
  endtask

  initial begin
    int  n;
    int  rises;
    int  starts0;
    bit  prev_act;
    bit  b;
    bit  r;
    bit  lr;

    // Reset and idle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 2'd2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 2'd2);
    check_val("idle_active", 32'(attack_active), 32'd0);
    check_val("idle_x", 32'(hero_attack_x_pos), 32'({12'd1025, 12'd1025}));
    check_val("idle_y", 32'(hero_attack_y_pos), 32'd0);
    check_val("idle_dir", 32'(attack_direction), 32'd1);

    // Facing RIGHT press with three-edge latency, then ACTIVE length
    set_heroes(100, 200, 500, 200);
    step(1'b1, 1'b0, 1'b0, 2'd2);
    step(1'b0, 1'b0, 1'b0, 2'd2);
    check_val("latency_not_yet", 32'(attack_active), 32'd0);
    step(1'b0, 1'b0, 1'b0, 2'd2);
    check_val("press_active", 32'(attack_active), 32'd1);
    check_val("press_x1", 32'(hero_attack_x_pos[11:0]),  32'd160);
    check_val("press_y1", 32'(hero_attack_y_pos[11:0]),  32'd220);
    check_val("press_x2", 32'(hero_attack_x_pos[23:12]), 32'd460);
    check_val("press_y2", 32'(hero_attack_y_pos[23:12]), 32'd220);
    check_val("press_dir", 32'(attack_direction), 32'd1);
    n = 1;
    for (int i = 0; i < 40 && attack_active; i++) begin
      step(1'b0, 1'b0, 1'b0, 2'd2);
      if (attack_active) n++;
    end
    check_val("active_len", 32'(n), 32'(ACT_CLKS));
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 2'd2);

    // Facing UP near the top edge saturates y
    set_heroes(300, 30, 600, 30);
    step(1'b1, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0);
    check_val("up_y1", 32'(hero_attack_y_pos[11:0]), 32'd0);
    check_val("up_x1", 32'(hero_attack_x_pos[11:0]), 32'd320);
    check_val("up_dir", 32'(attack_direction), 32'd0);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0, 2'd0);

    // Presses inside ACTIVE and COOLDOWN are dropped; one right after COOLDOWN is not
    set_heroes(100, 200, 500, 200);
    rises = 0;
    prev_act = attack_active;
    for (int i = 0; i < 30; i++) begin
      step((i == 0 || i == 6 || i == 17 || i == 23), 1'b0, 1'b0, 2'd1);
      if (attack_active && !prev_act) rises++;
      prev_act = attack_active;
      if (i == 25) check_val("repress_active", 32'(attack_active), 32'd1);
    end
    check_val("repress_rises", 32'(rises), 32'd2);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b0, 2'd1);

    // level_rst five clocks into ACTIVE aborts the attack
    for (int i = 0; i < 8; i++) step((i == 0), 1'b0, 1'b0, 2'd3);
    check_val("lrst_pre_active", 32'(attack_active), 32'd1);
    step(1'b0, 1'b0, 1'b1, 2'd3);
    check_val("lrst_active", 32'(attack_active), 32'd0);
    check_val("lrst_x", 32'(hero_attack_x_pos), 32'({12'd1025, 12'd1025}));
    check_val("lrst_y", 32'(hero_attack_y_pos), 32'd0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 2'd3);
    check_val("lrst_stays_idle", 32'(attack_active), 32'd0);

    // Button held for 40 clocks
    starts0 = m_starts;
    rises = 0;
    prev_act = attack_active;
    for (int i = 0; i < 70; i++) begin
      step((i < 40), 1'b0, 1'b0, 2'd2);
      if (attack_active && !prev_act) rises++;
      prev_act = attack_active;
    end
    check_val("hold_rises_model", 32'(rises), 32'(m_starts - starts0));
`ifndef ATTACK_AUTOREPEAT_EN
    check_val("hold_single", 32'(rises), 32'd1);
`endif

    // Randomized stimulus
    b = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) b = ~b;
      r  = ($urandom_range(0, 299) == 0);
      lr = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 3) == 0)
        set_heroes(int'($urandom_range(0, 960)), int'($urandom_range(0, 960)),
                   int'($urandom_range(0, 960)), int'($urandom_range(0, 960)));
      step(b, r, lr, 2'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_hero_attack_ctl
`default_nettype wire
